// File: rtl/vga_tile_pixel_gen_if.sv
// Memory-side bus of the tile pixel generator: tile-map RAM and glyph ROM read ports.
// Both memories are synchronous read with one cycle of latency.
interface vga_tile_pixel_gen_if;
    logic [11:0] map_addr;
    logic [15:0] map_data;
    logic [11:0] glyph_addr;
    logic [7:0]  glyph_data;

    modport master (output map_addr, output glyph_addr, input map_data, input glyph_data);
    modport slave  (input map_addr, input glyph_addr, output map_data, output glyph_data);
endinterface

// File: rtl/vga_tile_pixel_gen.sv
// Tile/glyph pixel generator: 80x30 map of 8x16 glyphs to RGB332 with a blinking block
// cursor; five-stage pipeline keeps sync and blank aligned with the pixel data.
module vga_tile_pixel_gen #(
    parameter int unsigned BLINK_FRAMES = 32,
    parameter int unsigned MAP_COLS     = 80,
    parameter int unsigned MAP_ROWS     = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            hcount_in,
    input  logic [9:0]            vcount_in,
    input  logic                  bright_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  cursor_en,
    input  logic [6:0]            cursor_col,
    input  logic [4:0]            cursor_row,
    vga_tile_pixel_gen_if.master  mem,
    output logic [7:0]            rgb,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  bright
);
    localparam int unsigned CNT_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    function automatic logic [7:0] palette(input logic [3:0] idx);
        logic [7:0] c;
        case (idx)
            4'h0: c = 8'h00;  4'h1: c = 8'h03;  4'h2: c = 8'h1C;  4'h3: c = 8'h1F;
            4'h4: c = 8'hE0;  4'h5: c = 8'hE3;  4'h6: c = 8'hFC;  4'h7: c = 8'hFF;
            4'h8: c = 8'h49;  4'h9: c = 8'h4B;  4'hA: c = 8'h5D;  4'hB: c = 8'h5F;
            4'hC: c = 8'hE9;  4'hD: c = 8'hEB;  4'hE: c = 8'hFD;  default: c = 8'hB6;
        endcase
        return c;
    endfunction

    logic [11:0]      map_addr_q, map_addr_d, glyph_addr_q, glyph_addr_d, row_ext;
    logic [7:0]       rgb_q, rgb_d;
    logic [4:0]       bright_sr_q, bright_sr_d, hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;
    logic [2:0]       xoff1_q, xoff1_d, xoff2_q, xoff2_d, xoff3_q, xoff3_d, xoff4_q, xoff4_d;
    logic [3:0]       grow1_q, grow1_d, grow2_q, grow2_d;
    logic [6:0]       col1_q, col1_d, col2_q, col2_d;
    logic [4:0]       row1_q, row1_d, row2_q, row2_d;
    logic [3:0]       fg3_q, fg3_d, bg3_q, bg3_d, fg4_q, fg4_d, bg4_q, bg4_d, colour;
    logic             hit3_q, hit3_d, hit4_q, hit4_d, pix;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             cursor_on_q, cursor_on_d, vs_prev_q, vs_prev_d;
    logic             unused_vcount_msb;

    // Tile rows only span 480 lines, so the top vcount bit never selects a row.
    assign unused_vcount_msb = vcount_in[9];

    always_comb begin
        // Stage 1: tile address (row*80 as two shifts) plus carried pixel coordinates.
        row_ext    = {7'd0, vcount_in[8:4]};
        map_addr_d = bright_in ? (row_ext << 6) + (row_ext << 4) + {5'd0, hcount_in[9:3]} : '0;
        xoff1_d    = hcount_in[2:0];
        grow1_d    = vcount_in[3:0];
        col1_d     = hcount_in[9:3];
        row1_d     = vcount_in[8:4];

        // Stage 2: wait for tile-map RAM data.
        xoff2_d = xoff1_q;
        grow2_d = grow1_q;
        col2_d  = col1_q;
        row2_d  = row1_q;

        // Stage 3: glyph address, colours and cursor match.
        glyph_addr_d = {mem.map_data[7:0], grow2_q};
        fg3_d        = mem.map_data[11:8];
        bg3_d        = mem.map_data[15:12];
        xoff3_d      = xoff2_q;
        hit3_d       = cursor_en & cursor_on_q & (col2_q == cursor_col) & (row2_q == cursor_row)
                     & (cursor_col < 7'(MAP_COLS)) & (cursor_row < 5'(MAP_ROWS));

        // Stage 4: wait for glyph ROM data.
        xoff4_d = xoff3_q;
        fg4_d   = fg3_q;
        bg4_d   = bg3_q;
        hit4_d  = hit3_q;

        // Stage 5: pixel select; a cursor hit swaps foreground and background.
        pix    = mem.glyph_data[3'd7 - xoff4_q];
        colour = (pix ^ hit4_q) ? fg4_q : bg4_q;
        rgb_d  = bright_sr_q[3] ? palette(colour) : '0;

        bright_sr_d = {bright_sr_q[3:0], bright_in};
        hs_sr_d     = {hs_sr_q[3:0], hsync_in};
        vs_sr_d     = {vs_sr_q[3:0], vsync_in};

        // Blink advances on vsync falling edges only, so it never changes mid-frame.
        vs_prev_d   = vsync_in;
        frame_cnt_d = frame_cnt_q;
        cursor_on_d = cursor_on_q;
        if (vs_prev_q && !vsync_in) begin
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                cursor_on_d = ~cursor_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            map_addr_q   <= '0;
            glyph_addr_q <= '0;
            rgb_q        <= '0;
            bright_sr_q  <= '0;
            hs_sr_q      <= '1;
            vs_sr_q      <= '1;
            xoff1_q      <= '0;
            xoff2_q      <= '0;
            xoff3_q      <= '0;
            xoff4_q      <= '0;
            grow1_q      <= '0;
            grow2_q      <= '0;
            col1_q       <= '0;
            col2_q       <= '0;
            row1_q       <= '0;
            row2_q       <= '0;
            fg3_q        <= '0;
            bg3_q        <= '0;
            fg4_q        <= '0;
            bg4_q        <= '0;
            hit3_q       <= 1'b0;
            hit4_q       <= 1'b0;
            frame_cnt_q  <= '0;
            cursor_on_q  <= 1'b1;
            vs_prev_q    <= 1'b1;
        end else begin
            map_addr_q   <= map_addr_d;
            glyph_addr_q <= glyph_addr_d;
            rgb_q        <= rgb_d;
            bright_sr_q  <= bright_sr_d;
            hs_sr_q      <= hs_sr_d;
            vs_sr_q      <= vs_sr_d;
            xoff1_q      <= xoff1_d;
            xoff2_q      <= xoff2_d;
            xoff3_q      <= xoff3_d;
            xoff4_q      <= xoff4_d;
            grow1_q      <= grow1_d;
            grow2_q      <= grow2_d;
            col1_q       <= col1_d;
            col2_q       <= col2_d;
            row1_q       <= row1_d;
            row2_q       <= row2_d;
            fg3_q        <= fg3_d;
            bg3_q        <= bg3_d;
            fg4_q        <= fg4_d;
            bg4_q        <= bg4_d;
            hit3_q       <= hit3_d;
            hit4_q       <= hit4_d;
            frame_cnt_q  <= frame_cnt_d;
            cursor_on_q  <= cursor_on_d;
            vs_prev_q    <= vs_prev_d;
        end
    end

    assign mem.map_addr   = map_addr_q;
    assign mem.glyph_addr = glyph_addr_q;
    assign rgb            = rgb_q;
    assign bright         = bright_sr_q[4];
    assign hsync          = hs_sr_q[4];
    assign vsync          = vs_sr_q[4];
endmodule

// File: tb/tb_vga_tile_pixel_gen.sv
// Bench for vga_tile_pixel_gen: directed literal checks plus randomized stimulus compared
// every cycle against a pixel-level reference model with BLINK_FRAMES = 2.
module tb_vga_tile_pixel_gen;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] hcount_in = '0, vcount_in = '0;
    logic       bright_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
    logic       cursor_en = 1'b0;
    logic [6:0] cursor_col = '0;
    logic [4:0] cursor_row = '0;
    logic [7:0] rgb;
    logic       hsync, vsync, bright;

    vga_tile_pixel_gen_if mem_if ();

    vga_tile_pixel_gen #(.BLINK_FRAMES(2), .MAP_COLS(80), .MAP_ROWS(30)) dut (
        .clk(clk), .reset(reset), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .bright_in(bright_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .mem(mem_if.master), .rgb(rgb), .hsync(hsync), .vsync(vsync), .bright(bright)
    );

    always #5 clk = ~clk;

    logic [15:0] map_mem [2400];
    logic [7:0]  rom     [4096];
    logic [7:0]  pal     [16] = '{8'h00, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF,
                                  8'h49, 8'h4B, 8'h5D, 8'h5F, 8'hE9, 8'hEB, 8'hFD, 8'hB6};

    always @(posedge clk) begin
        mem_if.map_data   <= map_mem[mem_if.map_addr];
        mem_if.glyph_data <= rom[mem_if.glyph_addr];
    end

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: output word {rgb, hsync, vsync, bright} for one input sample.
    localparam logic [10:0] IDLE_OUT = {8'h00, 1'b1, 1'b1, 1'b0};
    function automatic logic [10:0] model(int h, int v, bit b, bit hs, bit vs,
                                          bit cen, int cc, int cr, bit on);
        int col, row, ci;
        logic [15:0] t;
        logic [7:0] g;
        bit pix, hit;
        if (!b) return {8'h00, hs, vs, 1'b0};
        col = h / 8;
        row = (v % 512) / 16;
        t   = map_mem[row * 80 + col];
        g   = rom[int'(t[7:0]) * 16 + v % 16];
        pix = g[7 - h % 8];
        hit = cen && on && col == cc && row == cr;
        ci  = (pix != hit) ? int'(t[11:8]) : int'(t[15:12]);
        return {pal[ci], hs, vs, 1'b1};
    endfunction

    typedef struct { int h; int v; bit b; bit hs; bit vs; } in_t;
    localparam in_t IDLE_IN = '{h: 0, v: 0, b: 1'b0, hs: 1'b1, vs: 1'b1};
    in_t p0 = IDLE_IN, p1 = IDLE_IN;
    logic [10:0] d0 = IDLE_OUT, d1 = IDLE_OUT, d2 = IDLE_OUT;
    int  edges = 0;
    bit  vsp = 1;

    // Model pipeline: cursor state and cursor inputs are taken two edges after the sample.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            edges = 0; vsp = 1; p0 = IDLE_IN; p1 = IDLE_IN;
            d0 = IDLE_OUT; d1 = IDLE_OUT; d2 = IDLE_OUT;
        end else begin
            d2 = d1;
            d1 = d0;
            d0 = model(p1.h, p1.v, p1.b, p1.hs, p1.vs, cursor_en, int'(cursor_col),
                       int'(cursor_row), ((edges / 2) % 2) == 0);
            p1 = p0;
            p0 = '{h: int'(hcount_in), v: int'(vcount_in), b: bright_in,
                   hs: hsync_in, vs: vsync_in};
            if (vsp && !vsync_in) edges++;
            vsp = vsync_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ({rgb, hsync, vsync, bright} !== d2) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t: got rgb=%h hs=%b vs=%b br=%b expected rgb=%h hs=%b vs=%b br=%b",
                         $time, rgb, hsync, vsync, bright, d2[10:3], d2[2], d2[1], d2[0]);
            end
        end
    end

    task automatic drive(input int h, input int v, input bit b);
        hcount_in = 10'(h);
        vcount_in = 10'(v);
        bright_in = b;
    endtask

    task automatic probe(input int h, input int v, output logic [7:0] r);
        drive(h, v, 1);
        @(posedge clk); #1 drive(0, 0, 0);
        repeat (4) @(posedge clk);
        #1 r = rgb;
    endtask

    task automatic vpulse();
        vsync_in = 1'b0;
        @(posedge clk); #1 vsync_in = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    logic [7:0] glyph_exp [8] = '{8'h03, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'h03};
    logic [7:0] r;
    int low_cnt, first_low;

    initial begin
        for (int i = 0; i < 2400; i++) map_mem[i] = 16'($urandom);
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        map_mem[0]  = 16'h4141;
        rom[12'h410] = 8'b1000_0001;
        rom[12'h413] = 8'h5A;

        #2 reset = 1'b1;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Addressing
        drive(639, 479, 1); @(posedge clk); #1 chk("addr_max", int'(mem_if.map_addr), 2399);
        drive(8, 16, 1);    @(posedge clk); #1 chk("addr_81", int'(mem_if.map_addr), 81);
        drive(700, 16, 0);  @(posedge clk); #1 chk("addr_blank", int'(mem_if.map_addr), 0);
        drive(0, 3, 1);     @(posedge clk); #1 drive(0, 0, 0);
        repeat (2) @(posedge clk);
        #1 chk("glyph_addr", int'(mem_if.glyph_addr), 'h413);

        // Glyph row walk on tile (0,0), line 0
        for (int t = 0; t < 13; t++) begin
            if (t >= 5) chk($sformatf("glyph_px%0d", t - 5), int'(rgb), int'(glyph_exp[t - 5]));
            if (t < 8) drive(t, 0, 1); else drive(0, 0, 0);
            @(posedge clk); #1;
        end

        // Async reset mid-line, then first valid pixel exactly 5 clocks after release
        drive(0, 0, 1);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_rgb", int'(rgb), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_bright", int'(bright), 0);
        chk("rst_map_addr", int'(mem_if.map_addr), 0);
        chk("rst_glyph_addr", int'(mem_if.glyph_addr), 0);
        drive(0, 0, 0);
        @(posedge clk); #1 reset = 1'b0;
        drive(0, 0, 1);
        for (int t = 1; t <= 5; t++) begin
            @(posedge clk); #1 drive(0, 0, 0);
            if (t < 5) chk($sformatf("fill_rgb%0d", t), int'(rgb), 0);
            else       chk("first_rgb", int'(rgb), 'h03);
        end

        // hsync low for hcount 656..751 -> 96 clocks, first seen 5 clocks after 656
        low_cnt = 0; first_low = -1;
        for (int s = 0; s < 206; s++) begin
            if (!hsync) begin
                low_cnt++;
                if (first_low < 0) first_low = s;
            end
            if (s < 200) begin
                drive(600 + s, 0, 0);
                hsync_in = !((600 + s) >= 656 && (600 + s) <= 751);
            end else begin
                hsync_in = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("hsync_len", low_cnt, 96);
        chk("hsync_start", first_low, 61);

        // Cursor blink with BLINK_FRAMES = 2
        do_reset();
        cursor_en = 1'b1; cursor_col = '0; cursor_row = '0;
        probe(0, 0, r); chk("cur_on_px0", int'(r), 'hE0);
        probe(1, 0, r); chk("cur_on_px1", int'(r), 'h03);
        vpulse();
        probe(0, 0, r); chk("cur_frame1", int'(r), 'hE0);
        vpulse();
        probe(0, 0, r); chk("cur_off", int'(r), 'h03);
        vpulse(); vpulse();
        probe(0, 0, r); chk("cur_on_again", int'(r), 'hE0);
        cursor_en = 1'b0;
        probe(0, 0, r); chk("cur_disabled", int'(r), 'h03);
        cursor_en = 1'b1; cursor_col = 7'd100;
        probe(0, 0, r); chk("cur_out_of_range", int'(r), 'h03);
        cursor_col = '0;

        // Reset coinciding with a vsync falling edge, from state cursor off / frame 1
        vpulse(); vpulse(); vpulse();
        probe(0, 0, r); chk("pre_sim_off", int'(r), 'h03);
        reset = 1'b1; vsync_in = 1'b0;
        @(posedge clk); #1 vsync_in = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        probe(0, 0, r); chk("sim_on", int'(r), 'hE0);
        vpulse();
        probe(0, 0, r); chk("sim_frame1", int'(r), 'hE0);
        vpulse();
        probe(0, 0, r); chk("sim_off", int'(r), 'h03);

        // Randomized stimulus against the model
        for (int n = 0; n < 3000; n++) begin
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) reset = 1'b1;
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 1) == 0)
                    drive($urandom_range(0, 31), $urandom_range(0, 47), 1);
                else
                    drive($urandom_range(0, 639), $urandom_range(0, 479), 1);
            end else begin
                drive($urandom_range(0, 799), $urandom_range(0, 524), 0);
            end
            if ($urandom_range(0, 15) == 0) hsync_in = ~hsync_in;
            if ($urandom_range(0, 19) == 0) vsync_in = ~vsync_in;
            if ($urandom_range(0, 49) == 0) begin
                cursor_en  = ($urandom_range(0, 3) != 0);
                cursor_col = ($urandom_range(0, 7) == 0) ? 7'd100 : 7'($urandom_range(0, 3));
                cursor_row = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 2));
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        drive(0, 0, 0); hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_tile_pixel_gen.md
Name: vga_tile_pixel_gen

Overview:
Pixel-generation stage directly downstream of the VGA timing generator. It consumes hcount/vcount/bright/hsync/vsync and turns an 80x30 tile map of 8x16 glyphs into 8-bit RGB332 pixels. It drives one synchronous tile-map RAM read port and one synchronous glyph-ROM read port, and overlays a blinking block cursor. All sync and blank signals are delayed to stay aligned with the pixel-data pipeline.

Parameters:
BLINK_FRAMES, 32, frames per cursor blink half-period (>=2)
MAP_COLS, 80, tiles per row (fixed by 640/8)
MAP_ROWS, 30, tile rows (fixed by 480/16)

Ports:
clk  input  1  pixel clock (driven by timing generator pixel clock output)
reset  input  1  asynchronous, active-high reset
hcount_in  input  10  horizontal pixel counter from timing stage
vcount_in  input  10  vertical line counter from timing stage
bright_in  input  1  visible-area flag from timing stage
hsync_in  input  1  active-low hsync from timing stage
vsync_in  input  1  active-low vsync from timing stage
cursor_en  input  1  cursor overlay enable
cursor_col  input  7  cursor tile column (0..79)
cursor_row  input  5  cursor tile row (0..29)
map_addr  output  12  tile-map RAM address, row*80+col
map_data  input  16  tile word: [7:0] char code, [11:8] fg index, [15:12] bg index
glyph_addr  output  12  glyph ROM address {char[7:0], glyph_row[3:0]}
glyph_data  input  8  glyph row bits, bit7 = leftmost pixel
rgb  output  8  RGB332 pixel
hsync  output  1  delayed hsync
vsync  output  1  delayed vsync
bright  output  1  delayed visible flag

Behaviour:
- Memories: both are synchronous read, 1-cycle latency. Data is valid in the cycle after the address is registered.
- Pipeline stages, with E = rising clk edge, inputs sampled at edge N:
  - E(N+1): map_addr <= row*80+col, with col=hcount_in[9:3] and row=vcount_in[8:4]. If bright_in=0, map_addr <= 0. Pixel x-offset hcount_in[2:0], glyph row vcount_in[3:0], tile col/row, and syncs are carried in pipeline regs.
  - E(N+3): glyph_addr <= {map_data[7:0], glyph_row}. Register fg/bg indices and cursor_hit = cursor_en & cursor_on & (col==cursor_col) & (row==cursor_row).
  - E(N+5): pix = glyph_data[7 - xoff]. Colour = pix ? fg : bg; if cursor_hit, swap fg/bg. rgb <= bright_d ? palette(colour) : 8'h00.
- Latency: exactly 5 clk. hsync, vsync and bright are each delayed by a 5-deep shift register so they stay aligned with rgb.
- Multiply: row*80 = (row<<6)+(row<<4), 12-bit result. Maximum 29*80+79 = 2399, no overflow.
- Palette: fixed combinational 16-entry RGB332 table.
  - 0=00, 1=03, 2=1C, 3=1F, 4=E0, 5=E3, 6=FC, 7=FF, 8=49, 9=4B, A=5D, B=5F, C=E9, D=EB, E=FD, F=B6.
- Blink: vs_prev tracks vsync_in (reset 1). A falling edge (vs_prev=1, vsync_in=0) increments frame_cnt.
  - When frame_cnt == BLINK_FRAMES-1, the edge wraps frame_cnt to 0 and toggles cursor_on.
  - cursor_on changes at most once per frame, only during vsync, so it never tears a visible frame.
- cursor_en=0: no inversion anywhere. Blink counting continues regardless of cursor_en.
- Out-of-range cursor (col>79 or row>29): never matches, so no inversion.
- Reset (async, any time, including mid-line):
  - map_addr=0, glyph_addr=0, rgb=0, bright=0, hsync=1, vsync=1.
  - All pipeline regs 0 (sync stages 1), frame_cnt=0, cursor_on=1, vs_prev=1.
  - After deassertion, outputs reflect valid data 5 clk after the first sampled inputs. Stages 1..4 emit blank/inactive until filled.
- Blanking: outputs are driven purely from delayed inputs, with no state beyond the pipeline. rgb is 0 whenever delayed bright=0, regardless of memory data.

Test Plan:
- Reset: assert reset mid-frame -> rgb=00, hsync=1, vsync=1, bright=0, map_addr=0 immediately (async). Release -> first non-blank rgb exactly 5 clk after the first bright_in=1 sample.
- Addressing: hcount=639, vcount=479, bright=1 -> map_addr=2399 next edge. hcount=8, vcount=16 -> map_addr=81. hcount=700 with bright=0 -> map_addr=0.
- Glyph render: map_data=16'h4141 at tile (0,0), glyph ROM row0 of char 0x41 = 8'b1000_0001, walk hcount 0..7 on line 0.
  - Expected rgb sequence: E0,03,03,03,03,03,03,E0 (fg=1 -> 03 is bg? no: fg idx 1=03, bg idx 4=E0; pix=1 -> 03). Correct sequence: 03,E0,E0,E0,E0,E0,E0,03.
  - Each value is 5 clk after its hcount.
- Sync alignment: hsync_in low for hcount 656..751 -> hsync low for exactly 96 clk, starting 5 clk after hcount_in=656. Same check for vsync lines 490..491.
- Cursor/blink: cursor_en=1 at (0,0), BLINK_FRAMES=2.
  - Frames 0-1: tile (0,0) pixels inverted (03<->E0 swapped).
  - After 2nd vsync falling edge: not inverted. After 4th: inverted again.
  - cursor_en=0 -> never inverted.
- Simultaneous events: reset pulse coinciding with a vsync falling edge -> frame_cnt=0, cursor_on=1 after release, with no extra toggle.
